display_scroll_controller: RTL and testbench

Sequencer that feeds the Data_i / DecimalPoints_i inputs of the multiplexed 7-segment display driver. It stores a hex-nibble message written one nibble at a time. On command it scrolls the message right-to-left across the DIGITS-digit display at a fixed step rate, optionally looping, and reports completion. It sits between the host logic (UART/keypad command layer) and the display multiplexer.

---
 rtl/display_scroll_controller.sv | 170 +++++++++++++++++
 tb/tb_display_scroll_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scroll_controller.sv
// display_scroll_controller
//   Stores a hex-nibble message written one nibble at a time and scrolls it
//   right-to-left across a DIGITS-digit 7-segment display at a fixed step rate.
//   Padding nibbles enter the display before and after the message, so the
//   display starts and ends each pass blank.
//
// Ports
//   Clock            system clock, rising edge
//   Reset            synchronous, active-high
//   WriteData_i      nibble to append to the message
//   WriteStrobe_i    append WriteData_i this cycle (IDLE only, while not full)
//   Clear_i          empty the buffer, clear the error flag, abort any scroll
//   Start_i          (re)start a pass from the first message nibble
//   Stop_i           abort the scroll and freeze the display
//   Loop_i           sampled on the last step of a pass: 1 = run another pass
//   Data_o           display nibbles, digit 0 (rightmost) in bits [3:0]
//   DecimalPoints_o  marks the digit currently showing the last message nibble
//   Busy_o           high while scrolling
//   Done_o           one-cycle pulse when a non-looping pass completes
//   Error_o          sticky, set when a write is dropped
//   Length_o         number of nibbles stored
module display_scroll_controller #(
  parameter int          CLOCK_HZ       = 10_000_000,
  parameter int          STEP_PERIOD_US = 250_000,
  parameter int          DIGITS         = 8,
  parameter int          MSG_LEN        = 16,
  parameter logic [3:0]  PAD_NIBBLE     = 4'h0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [3:0]                   WriteData_i,
  input  logic                         WriteStrobe_i,
  input  logic                         Clear_i,
  input  logic                         Start_i,
  input  logic                         Stop_i,
  input  logic                         Loop_i,
  output logic [4*DIGITS-1:0]          Data_o,
  output logic [DIGITS-1:0]            DecimalPoints_o,
  output logic                         Busy_o,
  output logic                         Done_o,
  output logic                         Error_o,
  output logic [$clog2(MSG_LEN+1)-1:0] Length_o
);

  localparam int DELAY  = (CLOCK_HZ / 1_000_000) * STEP_PERIOD_US;
  localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int LEN_W  = $clog2(MSG_LEN + 1);
  localparam int POS_W  = $clog2(MSG_LEN + DIGITS + 1);
  localparam int ADDR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [4*DIGITS-1:0] PAD_ALL = {DIGITS{PAD_NIBBLE}};

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [POS_W-1:0]   pos_reg;
  logic [LEN_W-1:0]   length_reg;
  logic               error_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [4*DIGITS-1:0] data_reg;
  logic [DIGITS-1:0]  dp_reg;

  logic [3:0]         msg_mem [MSG_LEN];

  logic               cmd_write;
  logic               write_ok;
  logic               write_drop;
  logic               step;
  logic               last_step;
  logic               is_last;
  logic [3:0]         next_nibble;
  logic [4*DIGITS-1:0] data_shifted;
  logic [DIGITS-1:0]  dp_shifted;

  // A write only counts when no higher-priority command is present.
  assign cmd_write  = WriteStrobe_i && !Clear_i && !Stop_i && !Start_i;
  assign write_ok   = cmd_write && (state_reg == IDLE) && (length_reg < LEN_W'(MSG_LEN));
  assign write_drop = cmd_write && !write_ok;

  assign step        = (cnt_reg == CNT_W'(DELAY - 1));
  // Pos runs 0 .. Length+DIGITS-1 over a pass; past the message it feeds padding.
  assign last_step   = (pos_reg == POS_W'(length_reg) + POS_W'(DIGITS - 1));
  assign is_last     = ((pos_reg + POS_W'(1)) == POS_W'(length_reg));
  assign next_nibble = (pos_reg < POS_W'(length_reg)) ? msg_mem[pos_reg[ADDR_W-1:0]]
                                                      : PAD_NIBBLE;

  // The marker vector shifts in lockstep with the nibbles so the decimal point
  // follows the last message nibble across the display.
  generate
    if (DIGITS > 1) begin : g_shift
      assign data_shifted = {data_reg[4*DIGITS-5:0], next_nibble};
      assign dp_shifted   = {dp_reg[DIGITS-2:0], is_last};
    end else begin : g_shift_one
      assign data_shifted = next_nibble;
      assign dp_shifted   = is_last;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (write_ok) begin
      msg_mem[length_reg[ADDR_W-1:0]] <= WriteData_i;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || Clear_i) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      pos_reg    <= '0;
      length_reg <= '0;
      error_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      data_reg   <= PAD_ALL;
      dp_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      if (Stop_i) begin
        // Display is left frozen at whatever it shows now.
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        cnt_reg   <= '0;
      end else if (Start_i) begin
        if (length_reg != '0) begin
          state_reg <= SCROLL;
          busy_reg  <= 1'b1;
          cnt_reg   <= '0;
          pos_reg   <= '0;
          data_reg  <= PAD_ALL;
          dp_reg    <= '0;
        end
      end else begin
        if (state_reg == SCROLL) begin
          if (step) begin
            cnt_reg  <= '0;
            data_reg <= data_shifted;
            dp_reg   <= dp_shifted;
            if (last_step) begin
              pos_reg <= '0;
              if (!Loop_i) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end else begin
              pos_reg <= pos_reg + POS_W'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        if (write_ok) begin
          length_reg <= length_reg + LEN_W'(1);
        end
        if (write_drop) begin
          error_reg <= 1'b1;
        end
      end
    end
  end

  assign Data_o          = data_reg;
  assign DecimalPoints_o = dp_reg;
  assign Busy_o          = busy_reg;
  assign Done_o          = done_reg;
  assign Error_o         = error_reg;
  assign Length_o        = length_reg;

endmodule

// File: tb/tb_display_scroll_controller.sv
// Testbench for display_scroll_controller: directed scenarios followed by
// random traffic, all checked by a per-cycle scoreboard fed from a
// window-based reference model, plus directed spot checks.
module tb_display_scroll_controller;

  localparam int D     = 4;
  localparam int M     = 8;
  localparam int DELAY = 10;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, clr = 1'b0, stop = 1'b0, start = 1'b0, ws = 1'b0, loop = 1'b0;
  logic [3:0]  wd = 4'h0;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        busy, done, err;
  logic [3:0]  len;

  display_scroll_controller #(
    .CLOCK_HZ(10_000_000), .STEP_PERIOD_US(1), .DIGITS(D), .MSG_LEN(M), .PAD_NIBBLE(4'h0)
  ) dut (
    .Clock(clk), .Reset(rst), .WriteData_i(wd), .WriteStrobe_i(ws), .Clear_i(clr),
    .Start_i(start), .Stop_i(stop), .Loop_i(loop), .Data_o(data),
    .DecimalPoints_o(dp), .Busy_o(busy), .Done_o(done), .Error_o(err), .Length_o(len)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  len;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the display after k steps is a window onto the stream
  // (D pads, message, D pads); digit i shows stream item k-1-i.
  bit         m_scroll = 0;
  int         m_k = 0;
  int         m_t = 0;
  logic [3:0] m_msg[$];
  bit         m_err = 0;
  bit         m_done = 0;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;

  function automatic void show(int k);
    int L = m_msg.size();
    for (int i = 0; i < D; i++) begin
      int j = k - 1 - i;
      logic [3:0] nib = 4'h0;
      if (j >= 0 && j < L) nib = m_msg[j];
      m_data[4*i +: 4] = nib;
      m_dp[i] = (j == L - 1);
    end
  endfunction

  task automatic model_update();
    bit   was = m_scroll;
    exp_t e;
    m_done = 0;
    if (rst || clr) begin
      m_msg.delete();
      m_err = 0; m_scroll = 0; m_data = '0; m_dp = '0;
    end else if (stop) begin
      m_scroll = 0;
    end else if (start) begin
      if (m_msg.size() > 0) begin
        m_scroll = 1; m_k = 0; m_t = 0; m_data = '0; m_dp = '0;
      end
    end else begin
      if (m_scroll) begin
        m_t++;
        if (m_t == DELAY) begin
          m_t = 0;
          m_k++;
          show(m_k);
          if (m_k == m_msg.size() + D) begin
            if (loop) m_k = 0;
            else begin m_scroll = 0; m_done = 1; end
          end
        end
      end
      if (ws) begin
        if (!was && m_msg.size() < M) m_msg.push_back(wd);
        else m_err = 1;
      end
    end
    e.data = m_data; e.dp = m_dp; e.busy = m_scroll; e.done = m_done;
    e.err = m_err; e.len = 4'(m_msg.size());
    sb_q.push_back(e);
  endtask

  // Inputs are applied 2 time units after a rising edge; returns 2 units
  // after the edge that consumed them.
  task automatic drive(input bit r, c, sp, st, w, input logic [3:0] d);
    rst = r; clr = c; stop = sp; start = st; ws = w; wd = d;
    model_update();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic write_beef();
    drive(0, 0, 0, 0, 1, 4'hB);
    drive(0, 0, 0, 0, 1, 4'hE);
    drive(0, 0, 0, 0, 1, 4'hE);
    drive(0, 0, 0, 0, 1, 4'hF);
  endtask

  // Monitor: one DUT output sample per edge against the queued expectation.
  exp_t mon_e, mon_a;
  int   mon_n = 0;
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {data, dp, busy, done, err, len};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL scoreboard cycle %0d: got data=%h dp=%b busy=%b done=%b err=%b len=%0d, want data=%h dp=%b busy=%b done=%b err=%b len=%0d",
                 mon_n, mon_a.data, mon_a.dp, mon_a.busy, mon_a.done, mon_a.err, mon_a.len,
                 mon_e.data, mon_e.dp, mon_e.busy, mon_e.done, mon_e.err, mon_e.len);
      end
      mon_n++;
    end
  end

  initial begin
    // 1. reset
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(1, 0, 0, 0, 0, 4'h0);
    chk("reset data", data, 16'h0000);
    chk("reset flags", {8'h0, dp, busy, done, err, 1'b0}, 16'h0000);
    chk("reset len", {12'h0, len}, 16'h0000);

    // 2. single pass
    write_beef();
    chk("len after 4 writes", {12'h0, len}, 16'd4);
    loop = 0;
    drive(0, 0, 0, 1, 0, 4'h0);
    for (int i = 1; i <= 81; i++) begin
      idle(1);
      if (i == 10) chk("+10 data", data, 16'h000B);
      if (i == 20) chk("+20 data", data, 16'h00BE);
      if (i == 30) chk("+30 data", data, 16'h0BEE);
      if (i == 40) begin chk("+40 data", data, 16'hBEEF); chk("+40 dp", {12'h0, dp}, 16'h0001); end
      if (i == 50) begin chk("+50 data", data, 16'hEEF0); chk("+50 dp", {12'h0, dp}, 16'h0002); end
      if (i == 79) chk("+79 done", {15'h0, done}, 16'h0000);
      if (i == 80) begin
        chk("+80 data", data, 16'h0000);
        chk("+80 done", {15'h0, done}, 16'h0001);
        chk("+80 busy", {15'h0, busy}, 16'h0000);
      end
      if (i == 81) chk("+81 done", {15'h0, done}, 16'h0000);
    end

    // 3. looping pass
    loop = 1;
    drive(0, 0, 0, 1, 0, 4'h0);
    for (int i = 1; i <= 90; i++) begin
      idle(1);
      if (i == 80) begin
        chk("loop +80 data", data, 16'h0000);
        chk("loop +80 done", {15'h0, done}, 16'h0000);
        chk("loop +80 busy", {15'h0, busy}, 16'h0001);
      end
      if (i == 90) chk("loop +90 data", data, 16'h000B);
    end
    drive(0, 0, 1, 0, 0, 4'h0);
    loop = 0;

    // 4. overflow, clear, write during scroll
    drive(0, 1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 1, 4'(i + 1));
    chk("full len", {12'h0, len}, 16'd8);
    chk("full err", {15'h0, err}, 16'h0001);
    drive(0, 1, 0, 0, 0, 4'h0);
    chk("clear len", {12'h0, len}, 16'd0);
    chk("clear err", {15'h0, err}, 16'h0000);
    write_beef();
    drive(0, 0, 0, 1, 0, 4'h0);
    idle(3);
    drive(0, 0, 0, 0, 1, 4'h7);
    chk("scroll write len", {12'h0, len}, 16'd4);
    chk("scroll write err", {15'h0, err}, 16'h0001);
    drive(0, 0, 1, 0, 0, 4'h0);

    // 5. stop mid-scroll, start+stop, start with empty buffer
    drive(0, 0, 0, 1, 0, 4'h0);
    idle(24);
    drive(0, 0, 1, 0, 0, 4'h0);
    chk("stop data", data, 16'h00BE);
    chk("stop busy", {15'h0, busy}, 16'h0000);
    idle(15);
    chk("frozen data", data, 16'h00BE);
    drive(0, 0, 1, 1, 0, 4'h0);
    chk("start+stop busy", {15'h0, busy}, 16'h0000);
    idle(12);
    chk("start+stop data", data, 16'h00BE);
    drive(0, 1, 0, 0, 0, 4'h0);
    drive(0, 0, 0, 1, 0, 4'h0);
    chk("empty start busy", {15'h0, busy}, 16'h0000);

    // 6. reset mid-scroll
    write_beef();
    drive(0, 0, 0, 1, 0, 4'h0);
    idle(34);
    drive(1, 0, 0, 0, 0, 4'h0);
    chk("midreset data", data, 16'h0000);
    chk("midreset len", {12'h0, len}, 16'd0);
    chk("midreset busy/done", {14'h0, busy, done}, 16'h0000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, c, sp, st, w;
      if (n % 200 == 0) loop = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 999) < 2);
      c  = ($urandom_range(0, 499) < 2);
      sp = ($urandom_range(0, 399) < 1);
      st = ($urandom_range(0, 199) < 2);
      w  = ($urandom_range(0, 99) < 20);
      drive(r, c, sp, st, w, 4'($urandom_range(0, 15)));
    end
    idle(2);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
